// File: rtl/keystroke_scheduler_if.sv
// Key-event handshake between keystroke_scheduler (master) and core (slave).
// key_release exists only when KEY_RELEASE_EVENT_EN is defined.
interface keystroke_scheduler_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
`ifdef KEY_RELEASE_EVENT_EN
    logic       key_release;

    modport master (output key_code, output key_valid, output key_release, input key_ready);
    modport slave  (input key_code, input key_valid, input key_release, output key_ready);
`else
    modport master (output key_code, output key_valid, input key_ready);
    modport slave  (input key_code, input key_valid, output key_ready);
`endif
endinterface

// File: rtl/keystroke_scheduler.sv
// Debounces 12 raw key lines, detects presses, arbitrates lowest-index-first into an event FIFO.
// Optional macro KEY_RELEASE_EVENT_EN also queues release events, flagged on key_release.
module keystroke_scheduler #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [11:0]           keystroke,
    output logic [11:0]           key_held,
    output logic                  overflow,
    keystroke_scheduler_if.master evt
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
`ifdef KEY_RELEASE_EVENT_EN
    localparam int EW = 5;
`else
    localparam int EW = 4;
`endif
    localparam logic [15:0]   DB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [11:0]   ks_meta_q, ks_s_q;
    logic [11:0]   held_q, held_d, held_prev_q;
    logic [15:0]   cnt_q [12];
    logic [15:0]   cnt_d [12];
    logic [11:0]   rise, pend_q, pend_d, clr;
    logic          ovf_q, ovf_d;
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop, push, can_push;
    logic [3:0]    sel_idx;
    logic [EW-1:0] push_data;
`ifdef KEY_RELEASE_EVENT_EN
    logic [11:0]   fall, pend_rel_q, pend_rel_d, clr_rel;
    logic          sel_rel;
`endif

    assign key_held      = held_q;
    assign overflow      = ovf_q;
    assign rise          = held_q & ~held_prev_q;
    assign evt.key_valid = (count_q != '0);
    assign evt.key_code  = mem_q[rd_ptr_q][3:0];
`ifdef KEY_RELEASE_EVENT_EN
    assign fall            = ~held_q & held_prev_q;
    assign evt.key_release = mem_q[rd_ptr_q][4];
`endif

    // Debounce: a level change is accepted only after DEBOUNCE_CYCLES consecutive mismatches
    always_comb begin
        for (int i = 0; i < 12; i++) begin
            held_d[i] = held_q[i];
            cnt_d[i]  = cnt_q[i];
            if (ks_s_q[i] == held_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                held_d[i] = ~held_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // Arbiter: presses beat releases, lower index beats higher; descending scan so the lowest wins
    always_comb begin
        pop      = evt.key_valid && evt.key_ready;
        can_push = (count_q != FULL_CNT) || pop;
        push     = 1'b0;
        sel_idx  = '0;
        clr      = '0;
`ifdef KEY_RELEASE_EVENT_EN
        sel_rel  = 1'b0;
        clr_rel  = '0;
        if (can_push) begin
            for (int i = 11; i >= 0; i--) begin
                if (pend_rel_q[i]) begin
                    push    = 1'b1;
                    sel_rel = 1'b1;
                    sel_idx = 4'(i);
                end
            end
        end
`endif
        if (can_push) begin
            for (int i = 11; i >= 0; i--) begin
                if (pend_q[i]) begin
                    push    = 1'b1;
                    sel_idx = 4'(i);
`ifdef KEY_RELEASE_EVENT_EN
                    sel_rel = 1'b0;
`endif
                end
            end
        end
`ifdef KEY_RELEASE_EVENT_EN
        if (push && sel_rel) clr_rel[sel_idx] = 1'b1;
        if (push && !sel_rel) clr[sel_idx] = 1'b1;
        push_data = {sel_rel, sel_idx};
`else
        if (push) clr[sel_idx] = 1'b1;
        push_data = sel_idx;
`endif
    end

    // A second edge on a still-pending key is dropped and flagged
    always_comb begin
        pend_d = (pend_q & ~clr) | rise;
        ovf_d  = ovf_q | (|(pend_q & ~clr & rise));
`ifdef KEY_RELEASE_EVENT_EN
        pend_rel_d = (pend_rel_q & ~clr_rel) | fall;
        ovf_d      = ovf_d | (|(pend_rel_q & ~clr_rel & fall));
`endif
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ks_meta_q   <= '0;
            ks_s_q      <= '0;
            held_q      <= '0;
            held_prev_q <= '0;
            pend_q      <= '0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < 12; i++) cnt_q[i] <= '0;
            for (int j = 0; j < FIFO_DEPTH; j++) mem_q[j] <= '0;
`ifdef KEY_RELEASE_EVENT_EN
            pend_rel_q  <= '0;
`endif
        end else begin
            ks_meta_q   <= keystroke;
            ks_s_q      <= ks_meta_q;
            held_q      <= held_d;
            held_prev_q <= held_q;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            for (int i = 0; i < 12; i++) cnt_q[i] <= cnt_d[i];
            if (push) mem_q[wr_ptr_q] <= push_data;
`ifdef KEY_RELEASE_EVENT_EN
            pend_rel_q  <= pend_rel_d;
`endif
        end
    end
endmodule

// File: tb/tb_keystroke_scheduler.sv
// Directed bench for keystroke_scheduler: vector table for reset/power-up, hand sequences for corners.
module tb_keystroke_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] keystroke;
    logic [11:0] key_held;
    logic        overflow;
    int          n_checks = 0;
    int          n_fail   = 0;

    keystroke_scheduler_if evt_if ();

    keystroke_scheduler #(.DEBOUNCE_CYCLES(16), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .keystroke (keystroke),
        .key_held  (key_held),
        .overflow  (overflow),
        .evt       (evt_if.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst_n;
        logic [11:0] ks;
        logic        rdy;
        logic [7:0]  wt;
        logic [11:0] held;
        logic        vld;
        logic [3:0]  code;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [11:0] ks, logic rdy, logic [7:0] wt,
                                logic [11:0] held, logic vld, logic [3:0] code, logic ovf);
        vec_t v;
        v.rst_n = r; v.ks = ks; v.rdy = rdy; v.wt = wt;
        v.held = held; v.vld = vld; v.code = code; v.ovf = ovf;
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        keystroke = '0;
        evt_if.key_ready = 1'b0;
        tick(3);
        rst_n = 1'b1;
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0;
        keystroke = '0;
        evt_if.key_ready = 1'b0;

        // reset with all keys down, then 2+16 cycles to key_held, then codes 0..11 back to back
        vecs.push_back(mk(1'b0, 12'hFFF, 1'b1, 8'd3,  12'h000, 1'b0, 4'd0, 1'b0));
        vecs.push_back(mk(1'b1, 12'hFFF, 1'b1, 8'd17, 12'h000, 1'b0, 4'd0, 1'b0));
        vecs.push_back(mk(1'b1, 12'hFFF, 1'b1, 8'd1,  12'hFFF, 1'b0, 4'd0, 1'b0));
        vecs.push_back(mk(1'b1, 12'hFFF, 1'b1, 8'd1,  12'hFFF, 1'b0, 4'd0, 1'b0));
        for (int k = 0; k < 12; k++)
            vecs.push_back(mk(1'b1, 12'hFFF, 1'b1, 8'd1, 12'hFFF, 1'b1, 4'(k), 1'b0));
        vecs.push_back(mk(1'b1, 12'hFFF, 1'b1, 8'd1,  12'hFFF, 1'b0, 4'd0, 1'b0));

        tick(1);
        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n;
            keystroke = vecs[i].ks;
            evt_if.key_ready = vecs[i].rdy;
            tick(int'(vecs[i].wt));
            chk($sformatf("vec%0d.held", i), 32'(key_held), 32'(vecs[i].held));
            chk($sformatf("vec%0d.valid", i), 32'(evt_if.key_valid), 32'(vecs[i].vld));
            if (vecs[i].vld)
                chk($sformatf("vec%0d.code", i), 32'(evt_if.key_code), 32'(vecs[i].code));
            chk($sformatf("vec%0d.ovf", i), 32'(overflow), 32'(vecs[i].ovf));
        end

        // bounce on key 5 shorter than the debounce window
        do_reset();
        evt_if.key_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (c % 7 == 0) keystroke[5] = ~keystroke[5];
            tick(1);
            if (evt_if.key_valid || key_held[5]) seen = 1'b1;
        end
        chk("bounce.activity", 32'(seen), 32'd0);

        // backpressure: five presses, FIFO of four
        do_reset();
        keystroke = 12'h68C;
        tick(20);
        chk("bp.first_code", 32'(evt_if.key_code), 32'd2);
        tick(10);
        chk("bp.count", 32'(dut.count_q), 32'd4);
        chk("bp.pend10", 32'(dut.pend_q[10]), 32'd1);
        chk("bp.head", 32'(evt_if.key_code), 32'd2);
        evt_if.key_ready = 1'b1;
        tick(1); chk("bp.code3", 32'(evt_if.key_code), 32'd3);
        tick(1); chk("bp.code7", 32'(evt_if.key_code), 32'd7);
        tick(1); chk("bp.code9", 32'(evt_if.key_code), 32'd9);
        tick(1); chk("bp.code10", 32'(evt_if.key_code), 32'd10);
        chk("bp.valid10", 32'(evt_if.key_valid), 32'd1);
        tick(1); chk("bp.empty", 32'(evt_if.key_valid), 32'd0);
        chk("bp.ovf", 32'(overflow), 32'd0);

        // overflow: key 4 pending while FIFO full, then release and re-press
        do_reset();
        keystroke = 12'h01F;
        tick(30);
        chk("ovf.pend4", 32'(dut.pend_q[4]), 32'd1);
        keystroke = 12'h00F;
        tick(20);
        chk("ovf.held_rel", 32'(key_held), 32'h00F);
        chk("ovf.before", 32'(overflow), 32'd0);
        keystroke = 12'h01F;
        tick(18);
        chk("ovf.held_rep", 32'(key_held), 32'h01F);
        tick(2);
        chk("ovf.set", 32'(overflow), 32'd1);
        tick(10);
        chk("ovf.sticky", 32'(overflow), 32'd1);
        chk("ovf.head", 32'(evt_if.key_code), 32'd0);
        evt_if.key_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            chk($sformatf("ovf.drain%0d", k), 32'(evt_if.key_code), 32'(k));
        end
        tick(1);
        chk("ovf.single4", 32'(evt_if.key_valid), 32'd0);
        chk("ovf.still", 32'(overflow), 32'd1);

        // push and pop in the same cycle while full
        do_reset();
        keystroke = 12'h00F;
        tick(25);
        keystroke = 12'h80F;
        tick(22);
        chk("pp.pend11", 32'(dut.pend_q[11]), 32'd1);
        chk("pp.full", 32'(dut.count_q), 32'd4);
        evt_if.key_ready = 1'b1;
        tick(1);
        chk("pp.count", 32'(dut.count_q), 32'd4);
        chk("pp.code1", 32'(evt_if.key_code), 32'd1);
        tick(1); chk("pp.code2", 32'(evt_if.key_code), 32'd2);
        tick(1); chk("pp.code3", 32'(evt_if.key_code), 32'd3);
        tick(1); chk("pp.code11", 32'(evt_if.key_code), 32'd11);
        tick(1); chk("pp.empty", 32'(evt_if.key_valid), 32'd0);

        // reset while events are queued
        do_reset();
        keystroke = 12'h003;
        tick(25);
        chk("mr.queued", 32'(evt_if.key_valid), 32'd1);
        rst_n = 1'b0;
        keystroke = '0;
        tick(1);
        rst_n = 1'b1;
        chk("mr.valid", 32'(evt_if.key_valid), 32'd0);
        chk("mr.code", 32'(evt_if.key_code), 32'd0);
        chk("mr.held", 32'(key_held), 32'd0);
        evt_if.key_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick(1);
            if (evt_if.key_valid) seen = 1'b1;
        end
        chk("mr.discarded", 32'(seen), 32'd0);

`ifdef KEY_RELEASE_EVENT_EN
        // press then release key 6
        do_reset();
        evt_if.key_ready = 1'b1;
        keystroke = 12'h040;
        tick(20);
        chk("rel.press_valid", 32'(evt_if.key_valid), 32'd1);
        chk("rel.press_code", 32'(evt_if.key_code), 32'd6);
        chk("rel.press_flag", 32'(evt_if.key_release), 32'd0);
        keystroke = 12'h000;
        tick(20);
        chk("rel.rel_valid", 32'(evt_if.key_valid), 32'd1);
        chk("rel.rel_code", 32'(evt_if.key_code), 32'd6);
        chk("rel.rel_flag", 32'(evt_if.key_release), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
